// File: rtl/sram_dp_param.sv
// Parametrised single-clock true dual-port SRAM.
// Each write-enable lane is stored in its own memory array. Port B writes
// before port A in the same process, so port A wins on overlapping lanes.
// After reset a sequencer zero-fills every word before traffic is accepted.
// Reads are registered, with an optional second output register stage.
module sram_dp_param #(
  parameter int DATA_W         = 24,
  parameter int LANE_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int LANES         = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [LANES-1:0]  wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              douta_vld,
  input  logic              enb,
  input  logic [LANES-1:0]  web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              doutb_vld,
  output logic              init_busy,
  output logic              collision
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_X     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  logic              run, clearing;
  logic              a_in, b_in;
  logic              a_wr, a_rd, b_wr, b_rd;
  logic              same_addr;
  logic              collision_reg;
  logic              rd_a_vld_reg, rd_b_vld_reg;
  logic [DATA_W-1:0] rd_a_data, rd_b_data;

  assign run       = (state_reg == RUN);
  assign clearing  = (state_reg == CLEAR);
  assign init_busy = clearing;
  assign collision = collision_reg;

  // Out-of-range addresses drop writes and read back as zero.
  assign a_in      = ({1'b0, addra} < DEPTH_X);
  assign b_in      = ({1'b0, addrb} < DEPTH_X);
  assign a_wr      = run & ena & (|wea);
  assign a_rd      = run & ena & ~(|wea);
  assign b_wr      = run & enb & (|web);
  assign b_rd      = run & enb & ~(|web);
  assign same_addr = (addra == addrb);

  // Clear sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Clear sequencer next state: walk every address once, then run forever.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == CLEAR) begin
      cnt_next = cnt_reg + ADDR_W'(1);
      if (cnt_reg == LAST_ADDR) begin
        state_next = RUN;
        cnt_next   = '0;
      end
    end
  end

  // Collision flag: both ports wrote a shared lane of the same word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision_reg <= 1'b0;
    end else begin
      collision_reg <= a_wr & b_wr & same_addr & a_in & (|(wea & web));
    end
  end

  // First-stage read valid strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_vld_reg <= 1'b0;
      rd_b_vld_reg <= 1'b0;
    end else begin
      rd_a_vld_reg <= a_rd;
      rd_b_vld_reg <= b_rd;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] mem [DEPTH];
      logic [LANE_W-1:0] rd_a_q, rd_b_q;
      logic [LANE_W-1:0] din_a, din_b;
      logic [LANE_W-1:0] wdata_a;
      logic [ADDR_W-1:0] waddr_a;
      logic              we_a, we_b;
      logic              fwd_a, fwd_b;

      assign din_a   = dina[gi*LANE_W +: LANE_W];
      assign din_b   = dinb[gi*LANE_W +: LANE_W];

      // The clear sequencer borrows port A's write path.
      assign we_a    = !rst && (clearing || (a_wr && a_in && wea[gi]));
      assign waddr_a = clearing ? cnt_reg : addra;
      assign wdata_a = clearing ? '0 : din_a;
      assign we_b    = !rst && b_wr && b_in && web[gi];

      // Cross-port new-data forwarding, only when that policy is selected.
      assign fwd_a   = (RDW_MODE != 0) && we_b && same_addr;
      assign fwd_b   = (RDW_MODE != 0) && we_a && same_addr;

      // Lane write: B first, then A, so A owns overlapping lanes.
      always_ff @(posedge clk) begin
        if (we_b) mem[addrb]   <= din_b;
        if (we_a) mem[waddr_a] <= wdata_a;
      end

      // Port A lane read register; holds its value when no read is issued.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_a_q <= '0;
        end else if (a_rd) begin
          rd_a_q <= !a_in ? '0 : (fwd_a ? din_b : mem[addra]);
        end
      end

      // Port B lane read register; holds its value when no read is issued.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_b_q <= '0;
        end else if (b_rd) begin
          rd_b_q <= !b_in ? '0 : (fwd_b ? din_a : mem[addrb]);
        end
      end

      assign rd_a_data[gi*LANE_W +: LANE_W] = rd_a_q;
      assign rd_b_data[gi*LANE_W +: LANE_W] = rd_b_q;
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] out_a_reg, out_b_reg;
      logic              out_a_vld_reg, out_b_vld_reg;

      // Second output stage: adds one cycle of latency to both ports.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_a_reg     <= '0;
          out_b_reg     <= '0;
          out_a_vld_reg <= 1'b0;
          out_b_vld_reg <= 1'b0;
        end else begin
          out_a_vld_reg <= rd_a_vld_reg;
          out_b_vld_reg <= rd_b_vld_reg;
          if (rd_a_vld_reg) out_a_reg <= rd_a_data;
          if (rd_b_vld_reg) out_b_reg <= rd_b_data;
        end
      end

      assign douta     = out_a_reg;
      assign doutb     = out_b_reg;
      assign douta_vld = out_a_vld_reg;
      assign doutb_vld = out_b_vld_reg;
    end else begin : g_noreg
      assign douta     = rd_a_data;
      assign doutb     = rd_b_data;
      assign douta_vld = rd_a_vld_reg;
      assign doutb_vld = rd_b_vld_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sram_dp_param.sv
// Scoreboard bench for sram_dp_param: reads push expected data and arrival
// cycle into per-port queues; a negedge monitor pops and compares on vld.
module tb_sram_dp_param;

  localparam int DATA_W         = 24;
  localparam int LANE_W         = 8;
  localparam int ADDR_W         = 8;
  localparam int DEPTH          = 256;
  localparam int RDW_MODE       = 0;
  localparam int OUT_REG        = 0;
  localparam int CLEAR_ON_RESET = 1;
  localparam int LANES          = DATA_W / LANE_W;
  localparam int LAT            = (OUT_REG != 0) ? 2 : 1;

  logic              clk;
  logic              rst;
  logic              ena, enb;
  logic [LANES-1:0]  wea, web;
  logic [ADDR_W-1:0] addra, addrb;
  logic [DATA_W-1:0] dina, dinb;
  logic [DATA_W-1:0] douta, doutb;
  logic              douta_vld, doutb_vld;
  logic              init_busy, collision;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  sram_dp_param #(
    .DATA_W(DATA_W), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG), .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) dut (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta), .douta_vld(douta_vld),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(doutb), .doutb_vld(doutb_vld),
    .init_busy(init_busy), .collision(collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // One clock of stimulus on both ports; reads register their expected data.
  task automatic op(input logic ea, input logic [LANES-1:0] wa, input logic [ADDR_W-1:0] aa,
                    input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] xa,
                    input logic eb, input logic [LANES-1:0] wb, input logic [ADDR_W-1:0] ab,
                    input logic [DATA_W-1:0] db, input logic [DATA_W-1:0] xb);
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    @(posedge clk);
    #1;
    if (ea && wa == '0) qa.push_back('{xa, cyc + LAT - 1});
    if (eb && wb == '0) qb.push_back('{xb, cyc + LAT - 1});
    $display("cyc %0d  A en=%0b we=%b addr=%02h din=%06h | B en=%0b we=%b addr=%02h din=%06h",
             cyc, ea, wa, aa, da, eb, wb, ab, db);
    ena = 1'b0; wea = '0; enb = 1'b0; web = '0;
  endtask

  // Counts negedge samples with init_busy high, starting just after rst release.
  task automatic measure_clear(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      @(negedge clk);
      if (init_busy) n++;
      else break;
    end
    chk(name, n, DEPTH);
  endtask

  // Monitor: missing, unexpected, wrong or late read data on either port.
  always @(negedge clk) begin
    exp_t e;
    while (qa.size() > 0 && qa[0].c < cyc) begin
      e = qa.pop_front();
      n_vec++; n_fail++;
      $display("FAIL a_missing_vld: no vld by cyc %0d, required 0x%06h at cyc %0d", cyc, e.d, e.c);
    end
    while (qb.size() > 0 && qb[0].c < cyc) begin
      e = qb.pop_front();
      n_vec++; n_fail++;
      $display("FAIL b_missing_vld: no vld by cyc %0d, required 0x%06h at cyc %0d", cyc, e.d, e.c);
    end
    if (douta_vld) begin
      n_vec++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected_vld: douta=0x%06h at cyc %0d, required no vld", douta, cyc);
      end else begin
        e = qa.pop_front();
        if (douta !== e.d || cyc != e.c) begin
          n_fail++;
          $display("FAIL a_read: got 0x%06h at cyc %0d, required 0x%06h at cyc %0d", douta, cyc, e.d, e.c);
        end else begin
          $display("cyc %0d  A read 0x%06h ok", cyc, douta);
        end
      end
    end
    if (doutb_vld) begin
      n_vec++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_vld: doutb=0x%06h at cyc %0d, required no vld", doutb, cyc);
      end else begin
        e = qb.pop_front();
        if (doutb !== e.d || cyc != e.c) begin
          n_fail++;
          $display("FAIL b_read: got 0x%06h at cyc %0d, required 0x%06h at cyc %0d", doutb, cyc, e.d, e.c);
        end else begin
          $display("cyc %0d  B read 0x%06h ok", cyc, doutb);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    ena = 1'b0; wea = '0; addra = '0; dina = '0;
    enb = 1'b0; web = '0; addrb = '0; dinb = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_douta", douta, 0);
    chk("rst_doutb", doutb, 0);
    chk("rst_douta_vld", douta_vld, 0);
    chk("rst_doutb_vld", doutb_vld, 0);
    chk("rst_collision", collision, 0);
    chk("rst_init_busy", init_busy, 1);

    // Clear lasts DEPTH cycles; reads issued meanwhile must give no vld
    rst = 1'b0;
    ena = 1'b1; wea = '0; addra = 8'h40;
    enb = 1'b1; web = '0; addrb = 8'h41;
    measure_clear("clear_len");
    ena = 1'b0; enb = 1'b0;

    // First read after clear
    op(1, 3'b000, 8'h7F, 24'h0, 24'h000000, 0, 3'b000, 8'h00, 24'h0, 24'h0);

    // Full write then read on A
    op(1, 3'b111, 8'h10, 24'hABCDEF, 24'h0, 0, 3'b000, 8'h00, 24'h0, 24'h0);
    op(1, 3'b000, 8'h10, 24'h0, 24'hABCDEF, 0, 3'b000, 8'h00, 24'h0, 24'h0);

    // Lane-masked write on B
    op(1, 3'b111, 8'h05, 24'h112233, 24'h0, 0, 3'b000, 8'h00, 24'h0, 24'h0);
    op(0, 3'b000, 8'h00, 24'h0, 24'h0, 1, 3'b010, 8'h05, 24'hFFFFFF, 24'h0);
    op(0, 3'b000, 8'h00, 24'h0, 24'h0, 1, 3'b000, 8'h05, 24'h0, 24'h11FF33);

    // Overlapping write-write: A wins lane 1, collision pulses once
    op(1, 3'b011, 8'h20, 24'hAAAAAA, 24'h0, 1, 3'b110, 8'h20, 24'hBBBBBB, 24'h0);
    chk("collision_pulse", collision, 1);
    op(0, 3'b000, 8'h00, 24'h0, 24'h0, 0, 3'b000, 8'h00, 24'h0, 24'h0);
    chk("collision_one_cycle", collision, 0);
    op(1, 3'b000, 8'h20, 24'h0, 24'hBBAAAA, 0, 3'b000, 8'h00, 24'h0, 24'h0);

    // Disjoint lanes on the same word: both land, no collision
    op(1, 3'b001, 8'h21, 24'h000011, 24'h0, 1, 3'b110, 8'h21, 24'h222200, 24'h0);
    chk("collision_disjoint", collision, 0);
    op(0, 3'b000, 8'h00, 24'h0, 24'h0, 1, 3'b000, 8'h21, 24'h0, 24'h222211);

    // Cross-port read-during-write, full word
    op(1, 3'b111, 8'h30, 24'h000001, 24'h0, 0, 3'b000, 8'h00, 24'h0, 24'h0);
    op(1, 3'b000, 8'h30, 24'h0, (RDW_MODE != 0) ? 24'h000002 : 24'h000001,
       1, 3'b111, 8'h30, 24'h000002, 24'h0);
    chk("collision_rdw", collision, 0);
    op(1, 3'b000, 8'h30, 24'h0, 24'h000002, 0, 3'b000, 8'h00, 24'h0, 24'h0);

    // Cross-port read-during-write, partial lanes
    op(0, 3'b000, 8'h00, 24'h0, 24'h0, 1, 3'b111, 8'h31, 24'h123456, 24'h0);
    op(1, 3'b100, 8'h31, 24'hAABBCC, 24'h0,
       1, 3'b000, 8'h31, 24'h0, (RDW_MODE != 0) ? 24'hAA3456 : 24'h123456);
    op(0, 3'b000, 8'h00, 24'h0, 24'h0, 1, 3'b000, 8'h31, 24'h0, 24'hAA3456);

    // Same-address reads on both ports, then back-to-back pipelined reads
    op(1, 3'b000, 8'h20, 24'h0, 24'hBBAAAA, 1, 3'b000, 8'h20, 24'h0, 24'hBBAAAA);
    op(1, 3'b000, 8'h10, 24'h0, 24'hABCDEF, 1, 3'b000, 8'h05, 24'h0, 24'h11FF33);
    op(1, 3'b000, 8'h05, 24'h0, 24'h11FF33, 1, 3'b000, 8'h7F, 24'h0, 24'h000000);
    op(1, 3'b000, 8'h20, 24'h0, 24'hBBAAAA, 1, 3'b000, 8'h10, 24'h0, 24'hABCDEF);

    // Idle ports hold the last read data with vld low
    repeat (3) @(posedge clk);
    #1;
    chk("hold_douta", douta, 24'hBBAAAA);
    chk("hold_doutb", doutb, 24'hABCDEF);
    chk("hold_douta_vld", douta_vld, 0);

    // Reset with a read of 0x40 in flight: no vld, outputs zero
    ena = 1'b1; wea = '0; addra = 8'h40;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ena = 1'b0;
    #1;
    chk("inflight_douta", douta, 0);
    chk("inflight_douta_vld", douta_vld, 0);
    chk("inflight_busy", init_busy, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset 100 cycles into clear: clear restarts and runs a full DEPTH
    repeat (100) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midclear_busy", init_busy, 1);
    rst = 1'b0;
    measure_clear("clear_restart_len");

    // Earlier data is gone after the restarted clear
    op(1, 3'b000, 8'h10, 24'h0, 24'h000000, 1, 3'b000, 8'h05, 24'h0, 24'h000000);

    repeat (5) @(posedge clk);
    #1;
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_dp_param.md
Name: sram_dp_param

Overview:
Parametrised single-clock true dual-port SRAM model. It is the successor to the fixed 256x24 dual-port buffer feeding the systolic array. Both ports are serviced in the same cycle. It adds lane-granular write enables, a configurable cross-port read-during-write policy, write-collision resolution with a flag, an optional output register stage with read-valid strobes, and a post-reset zero-clear sequencer.

Parameters:
DATA_W, 24, word width; must be a multiple of LANE_W
LANE_W, 8, write-enable lane width; LANES = DATA_W/LANE_W
ADDR_W, 8, address width
DEPTH, 256, number of words; DEPTH <= 2**ADDR_W
RDW_MODE, 0, cross-port read-during-write: 0 = old data, 1 = new data
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
CLEAR_ON_RESET, 1, 1 = zero all words after reset before accepting traffic

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
ena  in  1  port A enable
wea  in  LANES  port A per-lane write enable
addra  in  ADDR_W  port A address
dina  in  DATA_W  port A write data
douta  out  DATA_W  port A read data
douta_vld  out  1  port A read data valid, 1-cycle pulse
enb  in  1  port B enable
web  in  LANES  port B per-lane write enable
addrb  in  ADDR_W  port B address
dinb  in  DATA_W  port B write data
doutb  out  DATA_W  port B read data
doutb_vld  out  1  port B read data valid
init_busy  out  1  clear sequence in progress; ports ignored
collision  out  1  1-cycle pulse: same-address, same-cycle write-write overlap occurred

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces the following:
  - douta = doutb = 0; douta_vld = doutb_vld = 0; collision = 0; pipeline registers = 0.
  - FSM state = CLEAR and clear counter = 0 when CLEAR_ON_RESET = 1; otherwise state = RUN and memory contents undefined.
  - init_busy = 1 in CLEAR, 0 in RUN.
- FSM states:
  - CLEAR: writes 0 to mem[cnt] each cycle, cnt++. On cnt == DEPTH-1 the last word is written, next state = RUN, and init_busy drops the following cycle. CLEAR takes exactly DEPTH cycles.
  - RUN: terminal until the next rst.
- In CLEAR, all port requests are discarded: no memory update, no vld, collision = 0.
- Reset asserted mid-CLEAR or mid-RUN: the in-flight read is dropped (no vld emitted) and CLEAR restarts from address 0.
- RUN, per port X (A or B), evaluated independently every cycle:
  - Write: enX && |weX. Lane i of mem[addrX] takes dinX lane i where weX[i] = 1; other lanes are kept. No read is produced.
  - Read: enX && weX == 0. Data is registered into doutX; doutX_vld = 1 after the read latency (1 cycle if OUT_REG = 0, 2 if OUT_REG = 1).
  - Idle (!enX): doutX holds its last value; doutX_vld = 0.
- Back-to-back reads are fully pipelined: one read per port per cycle, in order.
- Write-write to the same address in the same cycle:
  - Overlapping lanes take port A's data; non-overlapping lanes are written by their own port.
  - collision pulses the next cycle only if at least one lane overlaps.
- Read on one port and write on the other to the same address in the same cycle:
  - RDW_MODE = 0: all lanes return the pre-write value.
  - RDW_MODE = 1: written lanes return the new data; unwritten lanes return the stored data.
  - collision is not asserted.
- Same-port read and write cannot occur in one cycle; they are mutually exclusive by the we encoding.
- Address >= DEPTH (only possible when DEPTH < 2**ADDR_W): write dropped; read returns 0 with vld = 1.
- Simultaneous reads of the same address on both ports: both return identical data.

Test Plan:
- Reset with CLEAR_ON_RESET = 1, DEPTH = 256 -> init_busy high for exactly 256 cycles. Reads issued during CLEAR give no vld. First read after CLEAR of addr 0x7F -> 0x000000, vld 1 cycle later.
- A writes 0xABCDEF to 0x10 (wea = 3'b111); next cycle A reads 0x10 -> douta = 0xABCDEF, douta_vld pulse at +1 (OUT_REG = 0) or +2 (OUT_REG = 1).
- Pre-load 0x112233 at 0x05; B writes 0xFFFFFF with web = 3'b010; read -> 0x11FF33.
- Same cycle: A writes 0xAAAAAA (wea = 3'b011) and B writes 0xBBBBBB (web = 3'b110) to 0x20 -> mem = 0xBBAAAA, collision = 1 for one cycle.
- Pre-load 0x000001 at 0x30; A reads 0x30 while B writes 0x000002 (web = 3'b111) -> douta = 0x000001 (RDW_MODE = 0) / 0x000002 (RDW_MODE = 1); collision stays 0.
- Assert rst while 0x40 read is in flight and CLEAR is 100 cycles into a fresh run -> no vld, outputs 0, CLEAR restarts and lasts a full DEPTH cycles; prior data at 0x10 reads 0 afterwards.
